pipe_stage_skid_reg: RTL and testbench

//  Parametrised pipeline stage register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries PC plus an opaque packed payload of control and data fields.
//  - Adds valid/ready handshake, an optional skid entry, hazard hold, branch flush and a bubble counter.
//  - Sits between two stages; the hazard unit drives hold, branch resolution drives flush.

---
 rtl/pipe_stage_skid_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register between two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries PC plus an opaque payload with a valid/ready handshake, an optional skid
// entry, a hazard hold, a branch flush and a saturating bubble counter.
module pipe_stage_skid_reg #(
  parameter int unsigned PC_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH       = 96,
  parameter int unsigned SKID_EN          = 1,
  parameter int unsigned BUBBLE_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PC_WIDTH-1:0]         in_pc,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        hold,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_WIDTH-1:0]         out_pc,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_no_op,
  output logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt
);

  // EMPTY: nothing held; FULL: main entry only; SKID: main and skid entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t                  state;
  logic                    main_v;
  logic                    skid_v;
  logic                    accept;
  logic                    pop;
  logic [PC_WIDTH-1:0]     skid_pc;
  logic [DATA_WIDTH-1:0]   skid_data;

  // Valid bits are decoded from the state so they can never disagree with it.
  assign main_v = (state != ST_EMPTY);
  assign skid_v = (state == ST_SKID);

  // Hold and flush both mask the handshake; in the skid configuration ready
  // comes from registers only, otherwise it passes downstream ready through.
  assign in_ready  = ((SKID_EN != 0) ? ~skid_v : (~main_v | out_ready)) & ~hold & ~flush;
  assign out_valid = main_v & ~hold & ~flush;
  assign out_no_op = ~out_valid;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // State and main entry: flush clears valids only, hold freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_pc   <= '0;
      out_data <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (!hold) begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state    <= ST_FULL;
            out_pc   <= in_pc;
            out_data <= in_data;
          end
        end
        ST_FULL: begin
          if (accept && pop) begin
            out_pc   <= in_pc;
            out_data <= in_data;
          end else if (pop) begin
            state <= ST_EMPTY;
          end else if (accept) begin
            // Without a skid entry accept implies pop, so this branch is
            // only reachable when the skid entry exists.
            state <= (SKID_EN != 0) ? ST_SKID : ST_FULL;
          end
        end
        ST_SKID: begin
          if (pop) begin
            state    <= ST_FULL;
            out_pc   <= skid_pc;
            out_data <= skid_data;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Skid entry exists only when enabled; it captures input accepted while FULL
  // and the downstream stage is not consuming.
  generate
    if (SKID_EN != 0) begin : g_skid
      logic                  skid_load;
      logic [PC_WIDTH-1:0]   skid_pc_q;
      logic [DATA_WIDTH-1:0] skid_data_q;

      assign skid_load = ~flush & ~hold & (state == ST_FULL) & accept & ~pop;

      // Skid payload register; flush leaves the payload untouched.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          skid_pc_q   <= '0;
          skid_data_q <= '0;
        end else if (skid_load) begin
          skid_pc_q   <= in_pc;
          skid_data_q <= in_data;
        end
      end

      assign skid_pc   = skid_pc_q;
      assign skid_data = skid_data_q;
    end else begin : g_no_skid
      assign skid_pc   = '0;
      assign skid_data = '0;
    end
  endgenerate

  // Saturating count of post-reset cycles in which no instruction is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {BUBBLE_CNT_WIDTH{1'b1}})) begin
      bubble_cnt <= bubble_cnt + BUBBLE_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: default skid configuration, a 3-bit
// bubble counter instance and a no-skid instance.
module tb_pipe_stage_skid_reg;

  logic clk;
  logic rst_n;

  // Default configuration (SKID_EN=1)
  logic        iv, ir, hold, flush, ov, ordy, nop;
  logic [31:0] ipc, opc;
  logic [95:0] idata, odata;
  logic [15:0] bcnt;

  // BUBBLE_CNT_WIDTH=3 instance, kept idle
  logic        iv_s, ir_s, hold_s, flush_s, ov_s, ordy_s, nop_s;
  logic [31:0] ipc_s, opc_s;
  logic [95:0] idata_s, odata_s;
  logic [2:0]  bcnt_s;

  // SKID_EN=0 instance
  logic        iv_n, ir_n, hold_n, flush_n, ov_n, ordy_n, nop_n;
  logic [31:0] ipc_n, opc_n;
  logic [95:0] idata_n, odata_n;
  logic [15:0] bcnt_n;

  int n_chk;
  int n_err;

  pipe_stage_skid_reg u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_pc(ipc), .in_data(idata),
    .hold(hold), .flush(flush), .out_valid(ov), .out_ready(ordy), .out_pc(opc),
    .out_data(odata), .out_no_op(nop), .bubble_cnt(bcnt)
  );

  pipe_stage_skid_reg #(.BUBBLE_CNT_WIDTH(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .in_pc(ipc_s), .in_data(idata_s),
    .hold(hold_s), .flush(flush_s), .out_valid(ov_s), .out_ready(ordy_s), .out_pc(opc_s),
    .out_data(odata_s), .out_no_op(nop_s), .bubble_cnt(bcnt_s)
  );

  pipe_stage_skid_reg #(.SKID_EN(0)) u_noskid (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_ready(ir_n), .in_pc(ipc_n), .in_data(idata_n),
    .hold(hold_n), .flush(flush_n), .out_valid(ov_n), .out_ready(ordy_n), .out_pc(opc_n),
    .out_data(odata_n), .out_no_op(nop_n), .bubble_cnt(bcnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iv = 1'b0; ipc = '0; idata = '0; hold = 1'b0; flush = 1'b0; ordy = 1'b0;
    iv_s = 1'b0; ipc_s = '0; idata_s = '0; hold_s = 1'b0; flush_s = 1'b0; ordy_s = 1'b0;
    iv_n = 1'b0; ipc_n = '0; idata_n = '0; hold_n = 1'b0; flush_n = 1'b0; ordy_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    // Reset state
    do_reset();
    chk1("rst_ov", ov, 1'b0);
    chk1("rst_nop", nop, 1'b1);
    chk1("rst_ir", ir, 1'b1);
    chk("rst_pc", 128'(opc), 128'(32'h0));
    chk("rst_bcnt", 128'(bcnt), 128'(16'd0));
    chk("rst_bcnt_s", 128'(bcnt_s), 128'(3'd0));

    // 1: single instruction, one cycle latency
    iv = 1'b1; ipc = 32'h100; idata = 96'hA; ordy = 1'b1;
    settle();
    chk1("t1_ir", ir, 1'b1);
    chk1("t1_ov_before", ov, 1'b0);
    cyc();
    iv = 1'b0;
    settle();
    chk1("t1_ov", ov, 1'b1);
    chk("t1_pc", 128'(opc), 128'(32'h100));
    chk("t1_data", 128'(odata), 128'(96'hA));
    chk1("t1_nop", nop, 1'b0);
    chk("t1_bcnt", 128'(bcnt), 128'(16'd1));
    cyc();
    chk1("t1_drain", ov, 1'b0);
    chk("t1_bcnt2", 128'(bcnt), 128'(16'd1));

    // 2: fill main and skid, then drain in order
    do_reset();
    iv = 1'b1; ipc = 32'h0; idata = 96'h10; ordy = 1'b1;
    settle();
    chk1("t2_ir0", ir, 1'b1);
    cyc();
    ipc = 32'h4; idata = 96'h14; ordy = 1'b0;
    settle();
    chk1("t2_ir1", ir, 1'b1);
    chk("t2_main0", 128'(opc), 128'(32'h0));
    cyc();
    ipc = 32'h8; idata = 96'h18;
    settle();
    chk1("t2_ir_skid", ir, 1'b0);
    chk1("t2_ov_skid", ov, 1'b1);
    chk("t2_main_skid", 128'(opc), 128'(32'h0));
    cyc();
    chk1("t2_ir_stay", ir, 1'b0);
    chk("t2_main_stay", 128'(opc), 128'(32'h0));
    ordy = 1'b1;
    settle();
    chk("t2_out0", 128'(opc), 128'(32'h0));
    chk("t2_out0_d", 128'(odata), 128'(96'h10));
    cyc();
    chk("t2_out1", 128'(opc), 128'(32'h4));
    chk("t2_out1_d", 128'(odata), 128'(96'h14));
    chk1("t2_ir_free", ir, 1'b1);
    cyc();
    iv = 1'b0;
    settle();
    chk1("t2_ov2", ov, 1'b1);
    chk("t2_out2", 128'(opc), 128'(32'h8));
    chk("t2_out2_d", 128'(odata), 128'(96'h18));
    cyc();
    chk1("t2_empty", ov, 1'b0);

    // 3: flush from SKID drops everything including the flushed-cycle input
    do_reset();
    iv = 1'b1; ipc = 32'h40; idata = 96'h40;
    cyc();
    ipc = 32'h44; idata = 96'h44;
    cyc();
    chk1("t3_in_skid", ir, 1'b0);
    flush = 1'b1; ipc = 32'h48; idata = 96'h48; ordy = 1'b1;
    settle();
    chk1("t3_ov_fl", ov, 1'b0);
    chk1("t3_ir_fl", ir, 1'b0);
    cyc();
    flush = 1'b0; iv = 1'b0;
    settle();
    chk1("t3_ov_after", ov, 1'b0);
    chk1("t3_ir_after", ir, 1'b1);
    chk("t3_pc_kept", 128'(opc), 128'(32'h40));
    cyc();
    chk1("t3_no_emit", ov, 1'b0);
    // flush beats hold
    iv = 1'b1; ipc = 32'h50; idata = 96'h50; ordy = 1'b0;
    cyc();
    iv = 1'b0; hold = 1'b1; flush = 1'b1;
    settle();
    chk1("t3_hf_ir", ir, 1'b0);
    cyc();
    hold = 1'b0; flush = 1'b0;
    settle();
    chk1("t3_hf_ov", ov, 1'b0);
    iv = 1'b1; ipc = 32'h4C; idata = 96'h4C;
    cyc();
    iv = 1'b0;
    settle();
    chk1("t3_reload_ov", ov, 1'b1);
    chk("t3_reload_pc", 128'(opc), 128'(32'h4C));

    // 4: hold for three cycles emits bubbles, then the held entry once
    do_reset();
    iv = 1'b1; ipc = 32'h20; idata = 96'h20;
    cyc();
    iv = 1'b0; hold = 1'b1; ordy = 1'b1;
    settle();
    chk1("t4_ov_h", ov, 1'b0);
    chk1("t4_ir_h", ir, 1'b0);
    chk1("t4_nop_h", nop, 1'b1);
    chk("t4_bcnt1", 128'(bcnt), 128'(16'd1));
    cyc();
    chk("t4_bcnt2", 128'(bcnt), 128'(16'd2));
    cyc();
    chk("t4_bcnt3", 128'(bcnt), 128'(16'd3));
    cyc();
    hold = 1'b0;
    settle();
    chk("t4_bcnt4", 128'(bcnt), 128'(16'd4));
    chk1("t4_ov", ov, 1'b1);
    chk("t4_pc", 128'(opc), 128'(32'h20));
    cyc();
    chk1("t4_once", ov, 1'b0);
    chk("t4_bcnt_final", 128'(bcnt), 128'(16'd4));

    // 5: 3-bit bubble counter saturates at 7
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("t5_sat", 128'(bcnt_s), 128'((i > 7) ? 3'd7 : 3'(i)));
    end

    // 6: no skid: ready tracks downstream, full-throughput replacement
    do_reset();
    iv_n = 1'b1; ipc_n = 32'h200; idata_n = 96'h200; ordy_n = 1'b0;
    settle();
    chk1("t6_ir0", ir_n, 1'b1);
    cyc();
    ipc_n = 32'h204; idata_n = 96'h204;
    settle();
    chk1("t6_ir_blk", ir_n, 1'b0);
    chk("t6_pc0", 128'(opc_n), 128'(32'h200));
    ordy_n = 1'b1;
    settle();
    chk1("t6_ir_pass", ir_n, 1'b1);
    cyc();
    ipc_n = 32'h208; idata_n = 96'h208;
    settle();
    chk("t6_pc1", 128'(opc_n), 128'(32'h204));
    chk1("t6_ir1", ir_n, 1'b1);
    cyc();
    iv_n = 1'b0;
    settle();
    chk("t6_pc2", 128'(opc_n), 128'(32'h208));
    chk1("t6_ov2", ov_n, 1'b1);
    cyc();
    chk1("t6_empty", ov_n, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
